// File: rtl/divider_pkg.sv
// Shared state encoding and default operand width for the multi-cycle divider.
package divider_pkg;

    localparam int unsigned DIVIDER_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division stage: shift in a dividend bit, trial-subtract the divisor.
module divider_step
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIVIDER_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH:0]   rem_out,
    output logic             quotient_bit_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // rem_in < divisor keeps shifted < 2*divisor, so the diff MSB is a true borrow flag
    always_comb begin
        shifted          = {rem_in, dividend_bit_in};
        diff             = shifted - {2'b00, divisor_in};
        quotient_bit_out = ~diff[WIDTH+1];
        rem_out          = quotient_bit_out ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one bit per cycle.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIVIDER_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [2*WIDTH-1:0]   dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic                 valid_in,
    output logic [2*WIDTH-1:0]   quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic                 valid_out,
    output logic                 busy_out,
    output logic                 div_zero_out
);

    localparam int unsigned        CNT_W     = $clog2(2 * WIDTH) + 1;
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(2 * WIDTH - 1);

    div_state_t         state_q;
    logic [CNT_W-1:0]   iter_q;
    logic [2*WIDTH-1:0] shift_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH:0]     rem_q;
    logic [2*WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               valid_q;
    logic               busy_q;
    logic               div_zero_q;

    logic [WIDTH:0]     rem_d;
    logic               qbit_d;

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in           (rem_q),
        .dividend_bit_in  (shift_q[2*WIDTH-1]),
        .divisor_in       (divisor_q),
        .rem_out          (rem_d),
        .quotient_bit_out (qbit_d)
    );

    // shift_q drains dividend bits from the MSB while quotient bits fill from the LSB,
    // so after the last iteration it holds the complete quotient.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        shift_q    <= dividend_in;
                        divisor_q  <= divisor_in;
                        rem_q      <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        state_q    <= (divisor_in == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    shift_q <= {shift_q[2*WIDTH-2:0], qbit_d};
                    iter_q  <= iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (divisor_q == '0) begin
                        quotient_q  <= '1;
                        remainder_q <= '0;
                        div_zero_q  <= 1'b1;
                    end else begin
                        quotient_q  <= shift_q;
                        remainder_q <= rem_q[WIDTH-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient_out  = quotient_q;
    assign remainder_out = remainder_q;
    assign valid_out     = valid_q;
    assign busy_out      = busy_q;
    assign div_zero_out  = div_zero_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: arithmetic reference model, directed corner cases, random traffic.
module tb_divider;
    import divider_pkg::*;

    localparam int unsigned W  = DIVIDER_WIDTH;
    localparam int unsigned DW = 2 * W;

    typedef struct {
        logic [DW-1:0] q;
        logic [W-1:0]  r;
        logic          dz;
        int            accept_cyc;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] dividend_in = '0;
    logic [W-1:0]  divisor_in = '0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] quotient_out;
    logic [W-1:0]  remainder_out;
    logic          valid_out;
    logic          busy_out;
    logic          div_zero_out;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n_valid = 0;
    int            n_pushed = 0;
    logic [DW-1:0] last_q = '0;
    logic [W-1:0]  last_r = '0;

    divider #(.WIDTH(W)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .valid_in      (valid_in),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .div_zero_out  (div_zero_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_wide(input int unsigned bits);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        if (bits < DW) v = v & ((DW'(1) << bits) - DW'(1));
        return v;
    endfunction

    // Monitor: pops the scoreboard on every valid_out, otherwise checks results are held.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            last_q = '0;
            last_r = '0;
        end else if (valid_out) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_valid_out: got valid_out=1 at cycle %0d expected no pending request", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient_out, e.q);
                check("remainder", DW'(remainder_out), DW'(e.r));
                check("div_zero", DW'(div_zero_out), DW'(e.dz));
                check("latency", DW'(cyc - e.accept_cyc), DW'(e.lat));
                last_q = e.q;
                last_r = e.r;
            end
        end else begin
            check("quotient_hold", quotient_out, last_q);
            check("remainder_hold", DW'(remainder_out), DW'(last_r));
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [W-1:0] b, input bit track);
        exp_t          e;
        logic [DW-1:0] bw;
        logic [DW-1:0] rem_full;
        int            guard = 0;
        @(negedge clk);
        while (busy_out && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (busy_out) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy_out=1 after %0d cycles expected idle", guard);
            return;
        end
        dividend_in = a;
        divisor_in  = b;
        valid_in    = 1'b1;
        @(posedge clk);
        #1;
        valid_in    = 1'b0;
        dividend_in = rand_wide(DW);
        divisor_in  = $urandom;
        check("busy_after_accept", DW'(busy_out), DW'(1));
        if (track) begin
            bw = {{W{1'b0}}, b};
            if (b == '0) begin
                e.q  = '1;
                e.r  = '0;
                e.dz = 1'b1;
                e.lat = 1;
            end else begin
                e.q  = a / bw;
                rem_full = a % bw;
                e.r  = rem_full[W-1:0];
                e.dz = 1'b0;
                e.lat = DW + 1;
            end
            e.accept_cyc = cyc;
            sb.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (sb.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no completion by cycle %0d expected earlier finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] p;
        logic [DW-1:0] q;
        logic [W-1:0]  qw;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [W-1:0]  b;
        int unsigned   sel;

        p  = DW'(128'd308113484502254276214653084379069091219);
        q  = DW'(128'd193690634914747133184576417654126124729);
        qw = q[W-1:0];

        repeat (3) @(negedge clk);
        check("reset_quotient", quotient_out, '0);
        check("reset_remainder", DW'(remainder_out), '0);
        check("reset_valid", DW'(valid_out), '0);
        check("reset_busy", DW'(busy_out), '0);
        check("reset_div_zero", DW'(div_zero_out), '0);
        rst_n = 1'b1;

        issue(DW'(299), W'(23), 1'b1);
        issue(DW'(300), W'(13), 1'b1);
        issue(p * q, qw, 1'b1);
        issue(DW'(5), W'(0), 1'b1);
        issue(DW'(7), W'(9), 1'b1);
        issue('1, W'(1), 1'b1);
        wait_done();

        // Abort mid-operation: no result may appear for this request.
        issue(DW'(299), W'(23), 1'b0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient_out, '0);
        check("abort_remainder", DW'(remainder_out), '0);
        check("abort_valid", DW'(valid_out), '0);
        check("abort_busy", DW'(busy_out), '0);
        check("abort_div_zero", DW'(div_zero_out), '0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(DW'(299), W'(23), 1'b1);
        wait_done();

        // A request strobed during RUN must be dropped.
        issue(DW'(300), W'(13), 1'b1);
        repeat (50) @(negedge clk);
        dividend_in = DW'(1);
        divisor_in  = W'(1);
        valid_in    = 1'b1;
        @(negedge clk);
        valid_in    = 1'b0;
        wait_done();

        for (int i = 0; i < 40; i++) begin
            ra  = rand_wide($urandom_range(1, DW));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = '0;
            end else if (sel == 1) begin
                b = W'(1);
            end else begin
                rb = rand_wide($urandom_range(1, W));
                b  = rb[W-1:0];
            end
            issue(ra, b, 1'b1);
        end
        wait_done();
        repeat (5) @(negedge clk);
        check("valid_pulse_count", DW'(n_valid), DW'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
